// File: rtl/pipe_sequencer.sv
// pipe_sequencer: merges load-use/branch hazards with mul/div occupancy and halt drain
// into F/D/E stall and D/E/M flush controls for the 5-stage pipeline.
module pipe_sequencer #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lwReq,
  input  logic pcSrcE,
  input  logic mdE,
  input  logic haltReq,
  input  logic resumeReq,
  output logic stalF,
  output logic stalD,
  output logic stalE,
  output logic flushD,
  output logic flushE,
  output logic flushM,
  output logic mdBusy,
  output logic mdDone,
  output logic halted
);
  typedef enum logic [1:0] {RUN, MD, DRAIN, HALT} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic w_run, w_br, w_md, w_lw, w_hr, w_mds, w_mdz, w_dh;
  assign w_run = r_state == RUN;
  assign w_br  = w_run & pcSrcE;
  assign w_md  = w_run & ~pcSrcE & mdE;
  assign w_lw  = w_run & ~pcSrcE & ~mdE & lwReq;
  assign w_hr  = w_run & ~pcSrcE & ~mdE & ~lwReq & haltReq;
  assign w_mds = (r_state == MD) & (r_cnt != '0);
  assign w_mdz = (r_state == MD) & (r_cnt == '0);
  assign w_dh  = (r_state == DRAIN) | (r_state == HALT);
  // Outputs are Mealy and forced low while reset is held.
  assign stalF  = ~rst & (w_md | w_lw | w_hr | w_mds | w_dh);
  assign stalD  = ~rst & (w_md | w_lw | w_mds);
  assign stalE  = ~rst & (w_md | w_mds);
  assign flushD = ~rst & (w_br | w_hr | w_dh);
  assign flushE = ~rst & (w_br | w_lw | w_hr | w_dh);
  assign flushM = ~rst & (w_md | w_mds);
  assign mdBusy = ~rst & (r_state == MD);
  assign mdDone = ~rst & w_mdz;
  assign halted = ~rst & (r_state == HALT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_md) begin
            r_state <= MD;
            r_cnt   <= CNT_W'(MD_LATENCY - 2);
          end else if (w_hr) begin
            r_state <= DRAIN;
            r_cnt   <= CNT_W'(3);
          end
        end
        MD: begin
          if (w_mdz) r_state <= RUN;
          else r_cnt <= r_cnt - 1'b1;
        end
        DRAIN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= HALT;
        end
        HALT: if (resumeReq) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed-vector bench for pipe_sequencer with MD_LATENCY=4.
module tb_pipe_sequencer;
  logic clk = 0, rst = 1;
  logic lwReq = 0, pcSrcE = 0, mdE = 0, haltReq = 0, resumeReq = 0;
  logic stalF, stalD, stalE, flushD, flushE, flushM, mdBusy, mdDone, halted;
  logic [8:0] w_out;
  int total = 0, bad = 0;

  pipe_sequencer #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .lwReq(lwReq), .pcSrcE(pcSrcE), .mdE(mdE),
    .haltReq(haltReq), .resumeReq(resumeReq), .stalF(stalF), .stalD(stalD),
    .stalE(stalE), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .mdBusy(mdBusy), .mdDone(mdDone), .halted(halted)
  );

  always #5 clk = ~clk;
  // {stalF,stalD,stalE,flushD,flushE,flushM,mdBusy,mdDone,halted}
  assign w_out = {stalF, stalD, stalE, flushD, flushE, flushM, mdBusy, mdDone, halted};

  localparam logic [8:0] ZERO = 9'b000000000, MDS0 = 9'b111001000, MDS = 9'b111001100;
  localparam logic [8:0] MDD = 9'b000000110, BR = 9'b000110000, LW = 9'b110010000;
  localparam logic [8:0] DRN = 9'b100110000, HLT = 9'b100110001;

  // inputs {lwReq,pcSrcE,mdE,haltReq,resumeReq}
  task automatic set_in(input logic [4:0] v);
    {lwReq, pcSrcE, mdE, haltReq, resumeReq} = v;
  endtask

  task automatic test_reset;
    set_in(5'b11111);
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (w_out !== ZERO) begin bad++; $display("FAIL reset_hold[%0d] got=%b want=%b", i, w_out, ZERO); end
    end
    @(posedge clk); #1;
    set_in(5'b00000);
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (w_out !== ZERO) begin bad++; $display("FAIL reset_idle[%0d] got=%b want=%b", i, w_out, ZERO); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md;
    logic [4:0] iv[6];
    logic [8:0] ev[6];
    iv = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
    ev = '{MDS0, MDS, MDS, MDD, ZERO, ZERO};
    for (int i = 0; i < 6; i++) begin
      set_in(iv[i]);
      @(negedge clk);
      total++;
      if (w_out !== ev[i]) begin bad++; $display("FAIL md_seq[%0d] got=%b want=%b", i, w_out, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority;
    logic [4:0] iv[8];
    logic [8:0] ev[8];
    iv = '{5'b10100, 5'b10100, 5'b11110, 5'b10100, 5'b11000, 5'b10000, 5'b01010, 5'b00000};
    ev = '{MDS0, MDS, MDS, MDD, BR, LW, BR, ZERO};
    for (int i = 0; i < 8; i++) begin
      set_in(iv[i]);
      @(negedge clk);
      total++;
      if (w_out !== ev[i]) begin bad++; $display("FAIL prio[%0d] got=%b want=%b", i, w_out, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] iv[9];
    logic [8:0] ev[9];
    iv = '{5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    ev = '{MDS0, MDS, MDS, MDD, MDS0, MDS, MDS, MDD, ZERO};
    for (int i = 0; i < 9; i++) begin
      set_in(iv[i]);
      @(negedge clk);
      total++;
      if (w_out !== ev[i]) begin bad++; $display("FAIL b2b[%0d] got=%b want=%b", i, w_out, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt;
    logic [4:0] iv[10];
    logic [8:0] ev[10];
    iv = '{5'b00010, 5'b00010, 5'b10100, 5'b01000, 5'b00010, 5'b10100, 5'b00000, 5'b00001, 5'b00000, 5'b00000};
    ev = '{DRN, DRN, DRN, DRN, HLT, HLT, HLT, HLT, ZERO, ZERO};
    for (int i = 0; i < 10; i++) begin
      set_in(iv[i]);
      @(negedge clk);
      total++;
      if (w_out !== ev[i]) begin bad++; $display("FAIL halt[%0d] got=%b want=%b", i, w_out, ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_md;
    set_in(5'b00100);
    @(negedge clk);
    total++;
    if (w_out !== MDS0) begin bad++; $display("FAIL rst_md_start got=%b want=%b", w_out, MDS0); end
    @(posedge clk); #1;
    set_in(5'b00000);
    @(negedge clk);
    total++;
    if (w_out !== MDS) begin bad++; $display("FAIL rst_md_busy got=%b want=%b", w_out, MDS); end
    @(posedge clk); #1;
    rst = 1;
    #1;
    total++;
    if (w_out !== ZERO) begin bad++; $display("FAIL rst_md_async got=%b want=%b", w_out, ZERO); end
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (w_out !== ZERO) begin bad++; $display("FAIL rst_md_nodone[%0d] got=%b want=%b", i, w_out, ZERO); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      set_in(i == 0 ? 5'b00100 : 5'b00000);
      @(negedge clk);
      total++;
      if (w_out !== (i == 0 ? MDS0 : i < 3 ? MDS : i == 3 ? MDD : ZERO)) begin
        bad++;
        $display("FAIL rst_md_again[%0d] got=%b want=%b", i, w_out, (i == 0 ? MDS0 : i < 3 ? MDS : i == 3 ? MDD : ZERO));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_drain;
    for (int i = 0; i < 2; i++) begin
      set_in(i == 0 ? 5'b00010 : 5'b00000);
      @(negedge clk);
      total++;
      if (w_out !== DRN) begin bad++; $display("FAIL rst_drain_pre[%0d] got=%b want=%b", i, w_out, DRN); end
      @(posedge clk); #1;
    end
    rst = 1;
    #1;
    total++;
    if (w_out !== ZERO) begin bad++; $display("FAIL rst_drain_async got=%b want=%b", w_out, ZERO); end
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (w_out !== ZERO) begin bad++; $display("FAIL rst_drain_after[%0d] got=%b want=%b", i, w_out, ZERO); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_md;
    test_priority;
    test_back_to_back;
    test_halt;
    test_rst_md;
    test_rst_drain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
